// File: rtl/fault_row_matcher_if.sv
// fault_row_matcher_if: bus between the eNVM loader / weight-row source and the fault row matcher
//   wr_en, wr_addr, wr_data         fault-bitmap write port (row address, faulty-PE bitmap)
//   start                           begin a matching pass
//   row_valid, row_ready,
//   row_zero_mask                   weight-row zero-mask handshake
//   faulty_rows_mask                rows holding at least one faulty PE
//   match_success, match_failed,
//   all_faulty_matched              one-cycle allocation command pulses
//   faulty_addr, current_row_addr   command payload
//   busy, done                      pass status
// modport master drives the inputs of the matcher, modport slave is the matcher itself.
interface fault_row_matcher_if #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          start;
    logic          row_valid;
    logic          row_ready;
    logic [N-1:0]  row_zero_mask;
    logic [N-1:0]  faulty_rows_mask;
    logic          match_success;
    logic          match_failed;
    logic          all_faulty_matched;
    logic [AW-1:0] faulty_addr;
    logic [AW-1:0] current_row_addr;
    logic          busy;
    logic          done;

    modport master (
        output wr_en, wr_addr, wr_data, start, row_valid, row_zero_mask,
        input  row_ready, faulty_rows_mask, match_success, match_failed, all_faulty_matched,
               faulty_addr, current_row_addr, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, row_valid, row_zero_mask,
        output row_ready, faulty_rows_mask, match_success, match_failed, all_faulty_matched,
               faulty_addr, current_row_addr, busy, done
    );
endinterface

// File: rtl/fault_row_matcher.sv
// fault_row_matcher: stores the per-row faulty-PE bitmap and, for each weight row, issues one
// allocation command naming an unmatched faulty array row whose faulty columns all see zero weights.
//   clk    clock
//   rst_n  asynchronous active-low reset (clears bitmap, matched set, FSM and outputs)
//   bus    fault_row_matcher_if.slave: write port, start, zero-mask handshake, command pulses, status
// Build option FAULT_MATCH_PARALLEL_EN: evaluate all candidate rows in a single scan cycle
// (lowest index wins); default is a sequential one-candidate-per-cycle scan.
module fault_row_matcher #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
    input logic               clk,
    input logic               rst_n,
    fault_row_matcher_if.slave bus
);
    localparam int N = SYSTOLIC_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);
`ifdef FAULT_MATCH_PARALLEL_EN
    localparam bit PARALLEL = 1'b1;
`else
    localparam bit PARALLEL = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WAIT_ROW, SCAN, RESULT, DONE} state_t;

    state_t                      state, state_nx;
    logic [N-1:0][N-1:0]         bitmap;
    logic [N-1:0]                matched, mask, fmask, remaining;
    logic [ADDR_WIDTH-1:0]       scan_p, row_cnt, cand_idx, hit_idx;
    logic                        cand_hit, hit, accept;

    always_comb begin
        fmask = '0;
        for (int r = 0; r < N; r++) fmask[r] = |bitmap[r];
    end

    assign remaining            = fmask & ~matched;
    assign accept               = state == WAIT_ROW && bus.row_valid;
    assign bus.faulty_rows_mask = fmask;
    assign bus.row_ready        = state == WAIT_ROW;
    assign bus.busy             = state != IDLE;

    // A row covers the weight row when every faulty column carries a zero weight.
`ifdef FAULT_MATCH_PARALLEL_EN
    always_comb begin
        cand_hit = 1'b0;
        cand_idx = '0;
        for (int r = N - 1; r >= 0; r--) begin
            if (remaining[r] && (bitmap[r] & ~mask) == '0) begin
                cand_hit = 1'b1;
                cand_idx = ADDR_WIDTH'(r);
            end
        end
    end
`else
    assign cand_idx = scan_p;
    assign cand_hit = remaining[scan_p] && (bitmap[scan_p] & ~mask) == '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = bus.start ? WAIT_ROW : IDLE;
            WAIT_ROW: if (bus.row_valid) state_nx = remaining == '0 ? RESULT : SCAN;
            SCAN:     if (PARALLEL || cand_hit || scan_p == LAST) state_nx = RESULT;
            RESULT:   state_nx = row_cnt == LAST ? DONE : WAIT_ROW;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap                 <= '0;
            matched                <= '0;
            mask                   <= '0;
            scan_p                 <= '0;
            row_cnt                <= '0;
            hit                    <= 1'b0;
            hit_idx                <= '0;
            bus.match_success      <= 1'b0;
            bus.match_failed       <= 1'b0;
            bus.all_faulty_matched <= 1'b0;
            bus.faulty_addr        <= '0;
            bus.current_row_addr   <= '0;
            bus.done               <= 1'b0;
        end else begin
            bus.match_success      <= 1'b0;
            bus.match_failed       <= 1'b0;
            bus.all_faulty_matched <= 1'b0;
            bus.done               <= state == DONE;
            if (state == IDLE && bus.wr_en) bitmap[bus.wr_addr] <= bus.wr_data;
            if (state == IDLE && bus.start) begin
                matched <= '0;
                row_cnt <= '0;
            end
            if (accept) begin
                mask   <= bus.row_zero_mask;
                scan_p <= '0;
                hit    <= 1'b0;
            end
            if (state == SCAN) begin
                scan_p <= scan_p + 1'b1;
                if (cand_hit) begin
                    hit     <= 1'b1;
                    hit_idx <= cand_idx;
                end
            end
            // Exactly one command per weight row; a hit outranks the other two outcomes.
            if (state == RESULT) begin
                bus.current_row_addr <= row_cnt;
                if (hit) begin
                    bus.match_success <= 1'b1;
                    bus.faulty_addr   <= hit_idx;
                    matched[hit_idx]  <= 1'b1;
                end else if (remaining == '0) begin
                    bus.all_faulty_matched <= 1'b1;
                end else begin
                    bus.match_failed <= 1'b1;
                end
                if (row_cnt != LAST) row_cnt <= row_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fault_row_matcher.sv
// tb_fault_row_matcher: directed, table-driven bench for fault_row_matcher plus hand-written pass sequences
module tb_fault_row_matcher;
    localparam int N = 8;
`ifdef FAULT_MATCH_PARALLEL_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam logic [2:0] P_OK = 3'b100, P_FAILED = 3'b010, P_ALL = 3'b001;

    typedef struct {
        logic [N-1:0][N-1:0] bm;
        logic [N-1:0]        mask;
        logic [2:0]          pulses;
        int                  addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    fault_row_matcher_if #(.N(N)) bus();
    fault_row_matcher #(.SYSTOLIC_SIZE(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] p, input int addr);
        if (p == P_ALL) return 1;
        if (PAR) return 2;
        return p == P_OK ? addr + 2 : N + 1;
    endfunction

    function automatic vec_t mk(input int r0, input logic [7:0] d0, input int r1, input logic [7:0] d1,
                                input logic [7:0] m, input logic [2:0] p, input int a);
        vec_t v;
        v.bm = '0;
        if (r0 >= 0) v.bm[r0] = d0;
        if (r1 >= 0) v.bm[r1] = d1;
        v.mask = m;
        v.pulses = p;
        v.addr = a;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic write_row(input int a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'(a);
        bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic start_pass();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Handshake one zero mask; latency counts cycles after the accepting edge.
    task automatic send_row(input logic [7:0] m, output logic [2:0] pl, output int lat);
        int w = 0;
        while (!bus.row_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("row_ready before handshake", int'(bus.row_ready), 1);
        bus.row_valid = 1'b1;
        bus.row_zero_mask = m;
        @(posedge clk); #1;
        bus.row_valid = 1'b0;
        pl = '0;
        lat = 0;
        for (int k = 1; k <= 3 * N; k++) begin
            @(posedge clk); #1;
            pl = {bus.match_success, bus.match_failed, bus.all_faulty_matched};
            if (pl != 0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic expect_row(input string tag, input logic [7:0] m, input logic [2:0] ep,
                              input int ea, input int row);
        logic [2:0] pl;
        int lat;
        send_row(m, pl, lat);
        check({tag, " pulses"}, int'(pl), int'(ep));
        check({tag, " latency"}, lat, exp_lat(ep, ea));
        check({tag, " current_row_addr"}, int'(bus.current_row_addr), row);
        if (ep == P_OK) check({tag, " faulty_addr"}, int'(bus.faulty_addr), ea);
    endtask

    task automatic expect_done(input string tag);
        @(posedge clk); #1;
        check({tag, " done"}, int'(bus.done), 1);
        check({tag, " busy after done"}, int'(bus.busy), 0);
        @(posedge clk); #1;
        check({tag, " done one cycle"}, int'(bus.done), 0);
    endtask

    function automatic int all_outputs();
        return int'({bus.row_ready, bus.faulty_rows_mask, bus.match_success, bus.match_failed,
                     bus.all_faulty_matched, bus.faulty_addr, bus.current_row_addr, bus.busy, bus.done});
    endfunction

    initial begin
        vec_t vecs[10];
        logic [N-1:0] fm;
        bus.wr_en = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start = 1'b0;
        bus.row_valid = 1'b0;
        bus.row_zero_mask = '0;

        vecs[0] = mk(3, 8'h04, -1, 8'h00, 8'h04, P_OK, 3);
        vecs[1] = mk(3, 8'h04, -1, 8'h00, 8'h00, P_FAILED, 0);
        vecs[2] = mk(3, 8'h04, -1, 8'h00, 8'hFF, P_OK, 3);
        vecs[3] = mk(-1, 8'h00, -1, 8'h00, 8'h00, P_ALL, 0);
        vecs[4] = mk(1, 8'h01, 5, 8'h01, 8'h01, P_OK, 1);
        vecs[5] = mk(0, 8'hFF, -1, 8'h00, 8'hFF, P_OK, 0);
        vecs[6] = mk(7, 8'h80, 2, 8'h03, 8'h80, P_OK, 7);
        vecs[7] = mk(2, 8'h03, 6, 8'h0C, 8'h0C, P_OK, 6);
        vecs[8] = mk(4, 8'hF0, 5, 8'h0F, 8'h3C, P_FAILED, 0);
        vecs[9] = mk(4, 8'hF0, 5, 8'h0F, 8'h0F, P_OK, 5);

        // Reset state and write visibility
        do_reset();
        check("reset outputs", all_outputs(), 0);
        bus.wr_en = 1'b1;
        bus.wr_addr = 3'd3;
        bus.wr_data = 8'h04;
        check("mask before write edge", int'(bus.faulty_rows_mask), 0);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        check("mask after write", int'(bus.faulty_rows_mask), 'h08);

        // Single-row vectors: fresh bitmap, first weight row of a pass
        foreach (vecs[i]) begin
            do_reset();
            fm = '0;
            for (int r = 0; r < N; r++) begin
                if (vecs[i].bm[r] != 0) write_row(r, vecs[i].bm[r]);
                fm[r] = |vecs[i].bm[r];
            end
            check($sformatf("vec%0d faulty_rows_mask", i), int'(bus.faulty_rows_mask), int'(fm));
            start_pass();
            check($sformatf("vec%0d busy", i), int'(bus.busy), 1);
            expect_row($sformatf("vec%0d", i), vecs[i].mask, vecs[i].pulses, vecs[i].addr, 0);
        end

        // Miss, later cover, then nothing left to match for the rest of the pass
        do_reset();
        write_row(3, 8'h04);
        start_pass();
        expect_row("seqA row0", 8'h00, P_FAILED, 0, 0);
        expect_row("seqA row1", 8'hFF, P_OK, 3, 1);
        for (int r = 2; r < N; r++) expect_row($sformatf("seqA row%0d", r), 8'h00, P_ALL, 0, r);
        expect_done("seqA");

        // Two identical faulty rows are matched in index order
        do_reset();
        write_row(1, 8'h01);
        write_row(5, 8'h01);
        start_pass();
        expect_row("seqB row0", 8'h01, P_OK, 1, 0);
        expect_row("seqB row1", 8'h01, P_OK, 5, 1);
        for (int r = 2; r < N; r++) expect_row($sformatf("seqB row%0d", r), 8'h01, P_ALL, 0, r);
        expect_done("seqB");

        // Writes and start while busy are ignored
        do_reset();
        write_row(3, 8'h04);
        start_pass();
        write_row(2, 8'hFF);
        check("seqC write while busy", int'(bus.faulty_rows_mask), 'h08);
        expect_row("seqC row0", 8'h04, P_OK, 3, 0);
        start_pass();
        expect_row("seqC row1", 8'h00, P_ALL, 0, 1);

        // Reset in the middle of a scan
        do_reset();
        write_row(3, 8'h04);
        start_pass();
        bus.row_valid = 1'b1;
        bus.row_zero_mask = 8'h00;
        @(posedge clk); #1;
        bus.row_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid-scan reset outputs", all_outputs(), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("after reset idle", int'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
